// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, with bursts of up to MAX_BURST words.
// Optional per-requester word and stall counters are enabled by defining FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       grant,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]    stat_words,
  output logic [31:0]              stat_stall
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_r, grant_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_found;
  logic               gnt_req;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_r   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant_r   <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Encode the one-hot grant and pick the round-robin winner starting at rr_ptr.
  // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    int idx;
    gnt_idx   = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_r[i]) gnt_idx = PTR_W'(i);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_r;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    ack           = '0;
    gnt_req       = 1'b0;
    fifo_wr_data  = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) fifo_wr_data = req_data[i*WIDTH +: WIDTH];
    end

    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt          = BURST;
          grant_nxt          = '0;
          grant_nxt[sel_idx] = 1'b1;
          burst_cnt_nxt      = '0;
        end
      end
      BURST: begin
        gnt_req = |(grant_r & req);
        ack     = grant_r & req & {NUM_REQ{~fifo_full}};
        if (!gnt_req || ((|ack) && burst_cnt == CNT_W'(MAX_BURST - 1))) begin
          state_nxt     = IDLE;
          grant_nxt     = '0;
          burst_cnt_nxt = '0;
          rr_ptr_nxt    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end else if (|ack) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant      = grant_r;
  assign fifo_wr_en = |ack;

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [31:0] words_q [NUM_REQ];
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) words_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] && words_q[i] != '1) words_q[i] <= words_q[i] + 32'd1;
      end
      if (state == BURST && gnt_req && fifo_full && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    stat_words = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_words[i*32 +: 32] = words_q[i];
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a cycle-level reference model queues expected responses,
// a negedge monitor pops and compares them; directed scenarios followed by randomized traffic.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [N*32-1:0] stat_words;
  logic [31:0]     stat_stall;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .grant        (grant),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic         wr_en;
  } cyc_t;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } wr_t;

  cyc_t exp_cyc[$];
  wr_t  exp_wr[$];

  int           vectors     = 0;
  int           miscompares = 0;
  bit           chk_en      = 1'b0;
  logic [N-1:0] last_grant  = '0;
  int           word_cnt[N];

  // Reference model: who owns the port, words taken in this burst, where the next search starts.
  bit           m_busy  = 1'b0;
  int           m_owner = 0;
  int           m_cnt   = 0;
  int           m_ptr   = 0;
  logic [N-1:0] m_ack;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue what the model expects, advance the model, then move past the edge.
  task automatic cyc(input logic [N-1:0] r, input logic f, input logic rs);
    cyc_t e;
    wr_t  w;
    bit   greq;
    bit   wr;
    req       = r;
    fifo_full = f;
    rst_n     = rs;

    greq    = m_busy && r[m_owner];
    wr      = greq && !f;
    e.grant = m_busy ? (N'(1) << m_owner) : '0;
    e.ack   = wr ? (N'(1) << m_owner) : '0;
    e.wr_en = wr;
    m_ack   = e.ack;
    if (chk_en) begin
      exp_cyc.push_back(e);
      if (wr) begin
        w.idx  = m_owner;
        w.data = req_data[m_owner*W +: W];
        exp_wr.push_back(w);
      end
    end

    if (!rs) begin
      m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (r != '0) begin
        for (int k = 0; k < N; k++) begin
          if (r[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (!greq || (wr && m_cnt == MB - 1)) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_ptr  = (m_owner + 1) % N;
    end else if (wr) begin
      m_cnt++;
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) req_data[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) word_cnt[i] = 0;
  endtask

  // Monitor: one expectation per checked cycle; write data popped whenever the DUT writes.
  cyc_t mon_e;
  wr_t  mon_w;
  always @(negedge clk) begin
    if (chk_en && exp_cyc.size() != 0) begin
      mon_e = exp_cyc.pop_front();
      check("grant", grant, mon_e.grant);
      check("ack", ack, mon_e.ack);
      check("wr_en", fifo_wr_en, mon_e.wr_en);
      check("no_write_when_full", fifo_wr_en & fifo_full, 0);
      check("ack_within_grant", ack & ~grant, 0);
      last_grant = grant;
      for (int i = 0; i < N; i++) word_cnt[i] += int'(ack[i]);
      if (fifo_wr_en === 1'b1) begin
        check("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          mon_w = exp_wr.pop_front();
          check("wr_data", fifo_wr_data, mon_w.data);
          check("wr_ack_owner", ack, N'(1) << mon_w.idx);
        end
      end
    end
  end

  initial begin
    req       = '0;
    fifo_full = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    clear_counts();
    @(posedge clk);
    #1;
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    chk_en = 1'b1;

    // Reset state
    cyc('0, 1'b0, 1'b1);
    check("reset_grant", last_grant, 0);

    // Single requester: idle, 8 writes, bubble, 8 writes
    clear_counts();
    repeat (18) cyc(4'b0010, 1'b0, 1'b1);
    check("single_words", word_cnt[1], 16);
    check("single_grant", last_grant, 4'b0010);

    // Reset mid-burst
    cyc(4'b0010, 1'b0, 1'b0);
    repeat (4) cyc(4'b0010, 1'b0, 1'b1);
    check("pre_reset_grant", last_grant, 4'b0010);
    repeat (2) cyc(4'b1111, 1'b0, 1'b0);
    check("in_reset_grant", last_grant, 0);
    cyc(4'b1111, 1'b0, 1'b1);
    check("post_reset_idle", last_grant, 0);
    cyc(4'b1111, 1'b0, 1'b1);
    check("post_reset_grant", last_grant, 4'b0001);

    // All four requesting: 32 words in 36 cycles
    cyc(4'b1111, 1'b0, 1'b0);
    clear_counts();
    repeat (36) cyc(4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) check("all4_words", word_cnt[i], 8);
`ifdef FIFO_WR_ARBITER_STATS_EN
    for (int i = 0; i < N; i++) check("stat_words", stat_words[i*32 +: 32], 8);
    check("stat_stall_none", stat_stall, 0);
`endif

    // Full stall after the third word
    cyc(4'b0011, 1'b0, 1'b0);
    clear_counts();
    repeat (4) cyc(4'b0011, 1'b0, 1'b1);
    repeat (5) cyc(4'b0011, 1'b1, 1'b1);
    check("stall_grant", last_grant, 4'b0001);
    check("stall_words", word_cnt[0], 3);
    repeat (5) cyc(4'b0011, 1'b0, 1'b1);
    check("stall_total", word_cnt[0], 8);
    cyc(4'b0011, 1'b0, 1'b1);
    check("stall_bubble", last_grant, 0);
    cyc(4'b0011, 1'b0, 1'b1);
    check("stall_next_grant", last_grant, 4'b0010);
`ifdef FIFO_WR_ARBITER_STATS_EN
    check("stat_stall", stat_stall, 5);
`endif

    // Withdrawal after two words from requester 2
    cyc(4'b0100, 1'b0, 1'b0);
    clear_counts();
    repeat (3) cyc(4'b0100, 1'b0, 1'b1);
    cyc(4'b1011, 1'b0, 1'b1);
    check("withdraw_words", word_cnt[2], 2);
    check("withdraw_cycle_grant", last_grant, 4'b0100);
    cyc(4'b1111, 1'b0, 1'b1);
    check("withdraw_idle", last_grant, 0);
    cyc(4'b1111, 1'b0, 1'b1);
    check("withdraw_next_grant", last_grant, 4'b1000);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      cyc(N'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 199) != 0);
    end

    repeat (3) cyc('0, 1'b0, 1'b1);
    check("write_queue_drained", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
